// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, 3x3 window plus strobes and position counters out.
// The master drives pixels; the slave is the window generator.
interface window_gen_3x3_if;
    logic              pix_valid;
    logic signed [7:0] pix_in;
    logic signed [7:0] window [0:8];
    logic              win_valid;
    logic              frame_done;
    logic [9:0]        row_idx;
    logic [9:0]        col_idx;

    modport master (
        output pix_valid, pix_in,
        input  window, win_valid, frame_done, row_idx, col_idx
    );

    modport slave (
        input  pix_valid, pix_in,
        output window, win_valid, frame_done, row_idx, col_idx
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers hold rows r-2 and r-1,
// and a 3x3 shift register forms the neighbourhood ending at the latest pixel.
module window_gen_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst,
    window_gen_3x3_if.slave  win_if
);
    localparam int         AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

    logic              accept;
    logic [9:0]        col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [AW-1:0]     addr;
    logic signed [7:0] lb_top [0:IMG_W-1];
    logic signed [7:0] lb_mid [0:IMG_W-1];
    logic signed [7:0] top_rd, mid_rd;
    logic signed [7:0] new_col [0:2];
    logic signed [7:0] win_q [0:8];
    logic              win_valid_q;
    logic              frame_done_q;

    assign accept = win_if.pix_valid;
    assign addr   = col_q[AW-1:0];
    assign top_rd = lb_top[addr];
    assign mid_rd = lb_mid[addr];

    assign new_col[0] = top_rd;
    assign new_col[1] = mid_rd;
    assign new_col[2] = win_if.pix_in;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Line buffers are never cleared; row/col gating keeps stale data hidden.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb_top[addr] <= mid_rd;
            lb_mid[addr] <= win_if.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_q[3*i]     <= win_q[3*i + 1];
                win_q[3*i + 1] <= win_q[3*i + 2];
                win_q[3*i + 2] <= new_col[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= accept && (row_q >= 10'd2) && (col_q >= 10'd2);
            frame_done_q <= accept && (row_q == LAST_ROW) && (col_q == LAST_COL);
        end
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_win_out
            assign win_if.window[gi] = win_q[gi];
        end
    endgenerate

    assign win_if.win_valid  = win_valid_q;
    assign win_if.frame_done = frame_done_q;
    assign win_if.row_idx    = row_q;
    assign win_if.col_idx    = col_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 5x4 instance for the directed scenarios and a
// 28x28 instance for a random frame, both checked against a pixel-array model.
module tb_window_gen_3x3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    window_gen_3x3_if sif ();
    window_gen_3x3_if lif ();

    window_gen_3x3 #(.IMG_W(5), .IMG_H(4)) u_small (
        .clk(clk), .rst(rst), .win_if(sif.slave)
    );
    window_gen_3x3 #(.IMG_W(28), .IMG_H(28)) u_large (
        .clk(clk), .rst(rst), .win_if(lif.slave)
    );

    typedef struct packed {
        logic [71:0] w;
        logic        fd;
    } exp_t;

    exp_t              q_s[$];
    exp_t              q_l[$];
    logic signed [7:0] img [0:1][0:27][0:27];
    int                m_r [2];
    int                m_c [2];
    int                strobes [2];
    int                fds [2];
    logic [71:0]       fd_win [2];
    logic [71:0]       got_wins[$];
    logic [71:0]       t1_wins[$];
    int                vectors = 0;
    int                miscompares = 0;

    function automatic logic [71:0] pack_win(input bit sel);
        logic [71:0] pw;
        for (int k = 0; k < 9; k++) begin
            pw[71-8*k -: 8] = sel ? lif.window[k] : sif.window[k];
        end
        return pw;
    endfunction

    task automatic reset_model();
        for (int s = 0; s < 2; s++) begin
            m_r[s] = 0;
            m_c[s] = 0;
        end
        q_s.delete();
        q_l.delete();
    endtask

    task automatic clear_stats();
        for (int s = 0; s < 2; s++) begin
            strobes[s] = 0;
            fds[s] = 0;
            fd_win[s] = '0;
        end
        got_wins.delete();
    endtask

    // One clock of stimulus on the selected DUT plus the scoreboard checks for it.
    task automatic cycle(input bit sel, input bit v, input logic signed [7:0] p);
        exp_t        e;
        logic [71:0] prev_w, got_w;
        logic        exp_v, got_v, got_fd;
        logic [9:0]  got_r, got_c;
        int          w_, h_, qsz;
        w_ = sel ? 28 : 5;
        h_ = sel ? 28 : 4;
        @(negedge clk);
        if (sel) begin
            lif.pix_valid = v; lif.pix_in = p;
        end else begin
            sif.pix_valid = v; sif.pix_in = p;
        end
        prev_w = pack_win(sel);
        exp_v = 1'b0;
        e = '0;
        if (v) begin
            img[sel][m_r[sel]][m_c[sel]] = p;
            if (m_r[sel] >= 2 && m_c[sel] >= 2) begin
                for (int k = 0; k < 9; k++) begin
                    e.w[71-8*k -: 8] = img[sel][m_r[sel]-2+k/3][m_c[sel]-2+k%3];
                end
                e.fd = (m_r[sel] == h_-1) && (m_c[sel] == w_-1);
                if (sel) q_l.push_back(e); else q_s.push_back(e);
                exp_v = 1'b1;
            end
            if (m_c[sel] == w_-1) begin
                m_c[sel] = 0;
                m_r[sel] = (m_r[sel] == h_-1) ? 0 : m_r[sel] + 1;
            end else begin
                m_c[sel] = m_c[sel] + 1;
            end
        end
        @(posedge clk);
        #1;
        got_v  = sel ? lif.win_valid  : sif.win_valid;
        got_fd = sel ? lif.frame_done : sif.frame_done;
        got_r  = sel ? lif.row_idx    : sif.row_idx;
        got_c  = sel ? lif.col_idx    : sif.col_idx;
        got_w  = pack_win(sel);
        qsz    = sel ? q_l.size() : q_s.size();

        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL win_valid[%0d]: got %b want %b", sel, got_v, exp_v);
        end
        if (got_v === 1'b1) begin
            if (qsz == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe[%0d]: got strobe want none queued", sel);
            end else begin
                if (sel) e = q_l.pop_front(); else e = q_s.pop_front();
                vectors++;
                if (got_w !== e.w) begin
                    miscompares++;
                    $display("FAIL window[%0d]: got %h want %h", sel, got_w, e.w);
                end
                vectors++;
                if (got_fd !== e.fd) begin
                    miscompares++;
                    $display("FAIL frame_done[%0d]: got %b want %b", sel, got_fd, e.fd);
                end
            end
            strobes[sel]++;
            if (got_fd === 1'b1) begin
                fds[sel]++;
                fd_win[sel] = got_w;
            end
            if (!sel) got_wins.push_back(got_w);
        end else begin
            if (exp_v && qsz != 0) begin
                if (sel) void'(q_l.pop_front()); else void'(q_s.pop_front());
            end
            vectors++;
            if (got_fd !== 1'b0) begin
                miscompares++;
                $display("FAIL frame_done_idle[%0d]: got %b want 0", sel, got_fd);
            end
            if (!v) begin
                vectors++;
                if (got_w !== prev_w) begin
                    miscompares++;
                    $display("FAIL window_hold[%0d]: got %h want %h", sel, got_w, prev_w);
                end
            end
        end
        vectors++;
        if ({got_r, got_c} !== {10'(m_r[sel]), 10'(m_c[sel])}) begin
            miscompares++;
            $display("FAIL row_col[%0d]: got %0d,%0d want %0d,%0d", sel, got_r, got_c, m_r[sel], m_c[sel]);
        end
    endtask

    task automatic test_reset();
        logic [71:0] gw;
        @(negedge clk);
        rst = 1'b1;
        sif.pix_valid = 1'b1; sif.pix_in = 8'sd55;
        lif.pix_valid = 1'b1; lif.pix_in = -8'sd5;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            gw = pack_win(s[0]);
            vectors++;
            if (gw !== 72'd0) begin
                miscompares++;
                $display("FAIL reset_window[%0d]: got %h want 0", s, gw);
            end
            vectors++;
            if ((s ? lif.win_valid : sif.win_valid) !== 1'b0 ||
                (s ? lif.frame_done : sif.frame_done) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_strobes[%0d]: got %b%b want 00", s,
                         s ? lif.win_valid : sif.win_valid, s ? lif.frame_done : sif.frame_done);
            end
            vectors++;
            if ((s ? lif.row_idx : sif.row_idx) !== 10'd0 || (s ? lif.col_idx : sif.col_idx) !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_counters[%0d]: got %0d,%0d want 0,0", s,
                         s ? lif.row_idx : sif.row_idx, s ? lif.col_idx : sif.col_idx);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        sif.pix_valid = 1'b0;
        lif.pix_valid = 1'b0;
        reset_model();
        cycle(1'b0, 1'b0, 8'sd0);
    endtask

    task automatic test_stream();
        logic [71:0] first_exp;
        logic [71:0] fd_exp;
        first_exp = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
        fd_exp    = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 8'(i));
            if (i == 12) begin
                vectors++;
                if (sif.win_valid !== 1'b1 || pack_win(1'b0) !== first_exp) begin
                    miscompares++;
                    $display("FAIL t1_first_window: got %b/%h want 1/%h", sif.win_valid, pack_win(1'b0), first_exp);
                end
            end
        end
        cycle(1'b0, 1'b0, 8'sd0);
        vectors++;
        if (strobes[0] != 6 || fds[0] != 1) begin
            miscompares++;
            $display("FAIL t1_counts: got %0d strobes %0d done want 6 1", strobes[0], fds[0]);
        end
        vectors++;
        if (fd_win[0] !== fd_exp) begin
            miscompares++;
            $display("FAIL t1_done_window: got %h want %h", fd_win[0], fd_exp);
        end
        t1_wins = got_wins;
    endtask

    task automatic compare_to_t1(input string name);
        vectors++;
        if (got_wins.size() != t1_wins.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d want %0d", name, got_wins.size(), t1_wins.size());
        end else begin
            for (int i = 0; i < t1_wins.size(); i++) begin
                vectors++;
                if (got_wins[i] !== t1_wins[i]) begin
                    miscompares++;
                    $display("FAIL %s_win%0d: got %h want %h", name, i, got_wins[i], t1_wins[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int sent;
        int guard;
        bit v;
        clear_stats();
        sent = 0;
        guard = 0;
        while (sent < 20 && guard < 400) begin
            v = 1'($urandom_range(0, 1));
            cycle(1'b0, v, v ? 8'(sent) : 8'($urandom));
            if (v) sent++;
            guard++;
        end
        if (sent < 20) begin
            vectors++;
            miscompares++;
            $display("FAIL t2_budget: got %0d pixels want 20", sent);
        end
        repeat (3) cycle(1'b0, 1'b0, 8'sd0);
        compare_to_t1("t2");
    endtask

    task automatic test_back_to_back();
        logic [71:0] f2_exp;
        f2_exp = {8'd100, 8'd101, 8'd102, 8'd105, 8'd106, 8'd107, 8'd110, 8'd111, 8'd112};
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, (i < 20) ? 8'(i) : 8'(100 + i - 20));
            if (i == 32) begin
                vectors++;
                if (sif.win_valid !== 1'b1 || pack_win(1'b0) !== f2_exp) begin
                    miscompares++;
                    $display("FAIL t3_first_window: got %b/%h want 1/%h", sif.win_valid, pack_win(1'b0), f2_exp);
                end
            end
        end
        cycle(1'b0, 1'b0, 8'sd0);
        vectors++;
        if (strobes[0] != 12 || fds[0] != 2) begin
            miscompares++;
            $display("FAIL t3_counts: got %0d strobes %0d done want 12 2", strobes[0], fds[0]);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(i));
        @(negedge clk);
        rst = 1'b1;
        sif.pix_valid = 1'b1; sif.pix_in = 8'sd99;
        @(posedge clk);
        #1;
        vectors++;
        if (pack_win(1'b0) !== 72'd0 || sif.win_valid !== 1'b0 || sif.frame_done !== 1'b0 ||
            sif.row_idx !== 10'd0 || sif.col_idx !== 10'd0) begin
            miscompares++;
            $display("FAIL t4_reset_outputs: got %h %b %b %0d %0d want all 0",
                     pack_win(1'b0), sif.win_valid, sif.frame_done, sif.row_idx, sif.col_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        sif.pix_valid = 1'b0;
        reset_model();
        clear_stats();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'(i));
        cycle(1'b0, 1'b0, 8'sd0);
        compare_to_t1("t4");
    endtask

    task automatic test_sign();
        logic [71:0] sign_exp;
        sign_exp = 72'h80FF80FF80FF80FF80;
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, (i % 2 == 0) ? -8'sd128 : -8'sd1);
            if (i == 12) begin
                vectors++;
                if (pack_win(1'b0) !== sign_exp || !($signed(sif.window[8]) < 0)) begin
                    miscompares++;
                    $display("FAIL t5_sign_window: got %h want %h", pack_win(1'b0), sign_exp);
                end
            end
        end
        cycle(1'b0, 1'b0, 8'sd0);
    endtask

    task automatic test_random_frame();
        clear_stats();
        for (int i = 0; i < 28*28; i++) cycle(1'b1, 1'b1, 8'($urandom));
        cycle(1'b1, 1'b0, 8'sd0);
        vectors++;
        if (strobes[1] != 676 || fds[1] != 1) begin
            miscompares++;
            $display("FAIL t6_counts: got %0d strobes %0d done want 676 1", strobes[1], fds[1]);
        end
        vectors++;
        if (q_l.size() != 0) begin
            miscompares++;
            $display("FAIL t6_queue: got %0d pending want 0", q_l.size());
        end
    endtask

    initial begin
        sif.pix_valid = 1'b0; sif.pix_in = '0;
        lif.pix_valid = 1'b0; lif.pix_in = '0;
        reset_model();
        clear_stats();
        test_reset();
        test_stream();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        test_sign();
        test_random_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
